// File: rtl/watch_calendar.sv
// rtl/watch_calendar.sv - tick-prescaled Gregorian calendar counter with validated time-set
// Optional alarm compare (alarm_hms/alarm_hit) is built only when WATCH_ALARM_EN is defined.
module watch_calendar #(
   parameter int YEAR_W        = 12,
   parameter int YEAR_MIN      = 1,
   parameter int TICKS_PER_SEC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              set_valid,
   input  logic [YEAR_W+25:0] set_time,
   output logic              set_ack,
   output logic              set_err,
   output logic [YEAR_W-1:0] year,
   output logic [3:0]        month,
   output logic [4:0]        day,
   output logic [4:0]        hour,
   output logic [5:0]        minute,
   output logic [5:0]        second,
   output logic              leap,
   output logic              sec_pulse,
   output logic              day_pulse
`ifdef WATCH_ALARM_EN
   ,
   input  logic [16:0]       alarm_hms,
   output logic              alarm_hit
`endif
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0]     PRESC_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [YEAR_W-1:0] YMIN       = YEAR_W'(YEAR_MIN);
   localparam logic [YEAR_W-1:0] YMAX       = '1;

   function automatic logic is_leap(input logic [YEAR_W-1:0] y);
      logic [31:0] v;
      v = 32'(y);
      return ((v % 32'd4 == 32'd0) && (v % 32'd100 != 32'd0)) || (v % 32'd400 == 32'd0);
   endfunction

   // Out-of-range months fall into the 31-day default.
   function automatic logic [4:0] max_day(input logic [3:0] m, input logic lp);
      case (m)
         4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
         4'd2:                    return lp ? 5'd29 : 5'd28;
         default:                 return 5'd31;
      endcase
   endfunction

   logic [YEAR_W-1:0] year_q, year_d;
   logic [3:0]        month_q, month_d;
   logic [4:0]        day_q, day_d, hour_q, hour_d;
   logic [5:0]        min_q, min_d, sec_q, sec_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic              sec_pulse_q, sec_pulse_d, day_pulse_q, day_pulse_d;
   logic              ack_q, ack_d, err_q, err_d;

   logic [YEAR_W-1:0] s_year;
   logic [3:0]        s_month;
   logic [4:0]        s_day, s_hour;
   logic [5:0]        s_min, s_sec;
   logic              set_ok, adv;

   assign s_year  = set_time[YEAR_W+25:26];
   assign s_month = set_time[25:22];
   assign s_day   = set_time[21:17];
   assign s_hour  = set_time[16:12];
   assign s_min   = set_time[11:6];
   assign s_sec   = set_time[5:0];

   assign set_ok = (s_month >= 4'd1) && (s_month <= 4'd12) && (s_day != 5'd0)
                && (s_day <= max_day(s_month, is_leap(s_year)))
                && (s_hour <= 5'd23) && (s_min <= 6'd59) && (s_sec <= 6'd59)
                && (s_year >= YMIN);

   // A set request in the same cycle swallows the advance.
   assign adv = !set_valid && tick && (presc_q == PRESC_LAST);

   always_comb begin
      year_d      = year_q;
      month_d     = month_q;
      day_d       = day_q;
      hour_d      = hour_q;
      min_d       = min_q;
      sec_d       = sec_q;
      presc_d     = presc_q;
      sec_pulse_d = 1'b0;
      day_pulse_d = 1'b0;
      ack_d       = 1'b0;
      err_d       = 1'b0;
      if (set_valid) begin
         if (set_ok) begin
            year_d  = s_year;
            month_d = s_month;
            day_d   = s_day;
            hour_d  = s_hour;
            min_d   = s_min;
            sec_d   = s_sec;
            presc_d = '0;
            ack_d   = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end else if (tick && !adv) begin
         presc_d = presc_q + 1'b1;
      end else if (adv) begin
         presc_d     = '0;
         sec_pulse_d = 1'b1;
         if (sec_q != 6'd59) sec_d = sec_q + 6'd1;
         else begin
            sec_d = 6'd0;
            if (min_q != 6'd59) min_d = min_q + 6'd1;
            else begin
               min_d = 6'd0;
               if (hour_q != 5'd23) hour_d = hour_q + 5'd1;
               else begin
                  hour_d      = 5'd0;
                  day_pulse_d = 1'b1;
                  if (day_q != max_day(month_q, leap)) day_d = day_q + 5'd1;
                  else begin
                     day_d = 5'd1;
                     if (month_q != 4'd12) month_d = month_q + 4'd1;
                     else begin
                        month_d = 4'd1;
                        year_d  = (year_q == YMAX) ? YMIN : year_q + 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         year_q      <= YMIN;
         month_q     <= 4'd1;
         day_q       <= 5'd1;
         hour_q      <= '0;
         min_q       <= '0;
         sec_q       <= '0;
         presc_q     <= '0;
         sec_pulse_q <= 1'b0;
         day_pulse_q <= 1'b0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         year_q      <= year_d;
         month_q     <= month_d;
         day_q       <= day_d;
         hour_q      <= hour_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         presc_q     <= presc_d;
         sec_pulse_q <= sec_pulse_d;
         day_pulse_q <= day_pulse_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
      end
   end

`ifdef WATCH_ALARM_EN
   logic alarm_q;

   // Compared against the post-advance time so the hit lines up with the new display value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) alarm_q <= 1'b0;
      else      alarm_q <= adv && ({hour_d, min_d, sec_d} == alarm_hms);
   end

   assign alarm_hit = alarm_q;
`else
   // No alarm: the next-state time feeds only the calendar registers.
`endif

   assign year      = year_q;
   assign month     = month_q;
   assign day       = day_q;
   assign hour      = hour_q;
   assign minute    = min_q;
   assign second    = sec_q;
   assign leap      = is_leap(year_q);
   assign sec_pulse = sec_pulse_q;
   assign day_pulse = day_pulse_q;
   assign set_ack   = ack_q;
   assign set_err   = err_q;

endmodule

// File: tb/tb_watch_calendar.sv
// tb/tb_watch_calendar.sv - scoreboard bench for watch_calendar against a seconds-of-day calendar model
module tb_watch_calendar;

   localparam int YW  = 12;
   localparam int TPS = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          tick = 1'b0;
   logic          set_valid = 1'b0;
   logic [YW+25:0] set_time = '0;
   logic          set_ack, set_err, leap, sec_pulse, day_pulse;
   logic [YW-1:0] year;
   logic [3:0]    month;
   logic [4:0]    day, hour;
   logic [5:0]    minute, second;
   logic          ah;
`ifdef WATCH_ALARM_EN
   logic [16:0]   alarm_hms = '0;
   logic          alarm_hit;
   assign ah = alarm_hit;
`else
   assign ah = 1'b0;
`endif

   watch_calendar #(.YEAR_W(YW), .YEAR_MIN(1), .TICKS_PER_SEC(TPS)) dut (
      .clk(clk), .rst(rst), .tick(tick), .set_valid(set_valid), .set_time(set_time),
      .set_ack(set_ack), .set_err(set_err), .year(year), .month(month), .day(day),
      .hour(hour), .minute(minute), .second(second), .leap(leap),
      .sec_pulse(sec_pulse), .day_pulse(day_pulse)
`ifdef WATCH_ALARM_EN
      , .alarm_hms(alarm_hms), .alarm_hit(alarm_hit)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      bit ack, err, sp, dp, ah, lp;
      int y, mo, d, h, mi, s;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   int m_y = 1, m_mo = 1, m_d = 1, m_sod = 0, m_presc = 0, al_sod = -1;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit m_leap(int y);
      return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
   endfunction

   function automatic int m_mdays(int y, int mo);
      int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
      if (mo < 1 || mo > 12) return 0;
      if (mo == 2 && m_leap(y)) return 29;
      return tbl[mo-1];
   endfunction

   function automatic logic [YW+25:0] pack(int y, int mo, int d, int h, int mi, int s);
      return {y[11:0], mo[3:0], d[4:0], h[4:0], mi[5:0], s[5:0]};
   endfunction

   task automatic chk(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   task automatic step(input bit t, input bit sv, input logic [YW+25:0] st);
      exp_t e;
      bit   push;
      int   y, mo, d, h, mi, s;
      tick = t;
      set_valid = sv;
      set_time = st;
      e = '{default: 0};
      push = 0;
      if (sv) begin
         y = int'(st[37:26]); mo = int'(st[25:22]); d = int'(st[21:17]);
         h = int'(st[16:12]); mi = int'(st[11:6]);  s = int'(st[5:0]);
         push = 1;
         if (y >= 1 && mo >= 1 && mo <= 12 && d >= 1 && d <= m_mdays(y, mo)
             && h <= 23 && mi <= 59 && s <= 59) begin
            m_y = y; m_mo = mo; m_d = d; m_sod = h * 3600 + mi * 60 + s;
            m_presc = 0;
            e.ack = 1;
         end else begin
            e.err = 1;
         end
      end else if (t) begin
         if (m_presc == TPS - 1) begin
            m_presc = 0;
            push = 1;
            e.sp = 1;
            m_sod++;
            if (m_sod == 86400) begin
               m_sod = 0;
               e.dp = 1;
               m_d++;
               if (m_d > m_mdays(m_y, m_mo)) begin
                  m_d = 1;
                  m_mo++;
                  if (m_mo > 12) begin
                     m_mo = 1;
                     m_y = (m_y == 4095) ? 1 : m_y + 1;
                  end
               end
            end
`ifdef WATCH_ALARM_EN
            e.ah = (m_sod == al_sod);
`endif
         end else begin
            m_presc++;
         end
      end
      if (push) begin
         e.y = m_y; e.mo = m_mo; e.d = m_d;
         e.h = m_sod / 3600; e.mi = (m_sod / 60) % 60; e.s = m_sod % 60;
         e.lp = m_leap(m_y);
         e.cyc = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   function automatic bit same(exp_t a, exp_t b);
      return a.ack == b.ack && a.err == b.err && a.sp == b.sp && a.dp == b.dp && a.ah == b.ah
          && a.lp == b.lp && a.y == b.y && a.mo == b.mo && a.d == b.d
          && a.h == b.h && a.mi == b.mi && a.s == b.s;
   endfunction

   always @(negedge clk) begin
      exp_t e, g;
      g = '{default: 0};
      g.ack = set_ack; g.err = set_err; g.sp = sec_pulse; g.dp = day_pulse; g.ah = ah;
      g.lp = leap; g.y = int'(year); g.mo = int'(month); g.d = int'(day);
      g.h = int'(hour); g.mi = int'(minute); g.s = int'(second);
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         checks++;
         if (!same(g, e)) begin
            errors++;
            $display("FAIL event@%0d: got ack%0b err%0b sp%0b dp%0b ah%0b %0d-%0d-%0d %0d:%0d:%0d lp%0b, expected ack%0b err%0b sp%0b dp%0b ah%0b %0d-%0d-%0d %0d:%0d:%0d lp%0b",
                     cyc, g.ack, g.err, g.sp, g.dp, g.ah, g.y, g.mo, g.d, g.h, g.mi, g.s, g.lp,
                     e.ack, e.err, e.sp, e.dp, e.ah, e.y, e.mo, e.d, e.h, e.mi, e.s, e.lp);
         end
      end else if (g.ack || g.err || g.sp || g.dp || g.ah) begin
         checks++;
         errors++;
         $display("FAIL spurious@%0d: ack%0b err%0b sp%0b dp%0b ah%0b, expected no pulse",
                  cyc, g.ack, g.err, g.sp, g.dp, g.ah);
      end
   end

   initial begin
      int pick, y, mo, d;
      int ylist[7] = '{4095, 2000, 2100, 1900, 2024, 0, 1};
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      chk("reset_date", {20'(year), 4'(month), 5'(day), 3'd0}, {20'd1, 4'd1, 5'd1, 3'd0});
      chk("reset_time", {hour, minute, second}, 17'd0);
      chk("reset_pulses", {set_ack, set_err, sec_pulse, day_pulse, ah}, 5'd0);

      for (int i = 0; i < 3 * TPS; i++) begin
         step(1'b1, 1'b0, '0);
         if (i % 3 == 1) step(1'b0, 1'b0, '0);
      end
      chk("t1_seconds", second, 3);

      step(1'b0, 1'b1, pack(2024, 2, 28, 23, 59, 59));
      repeat (TPS) step(1'b1, 1'b0, '0);
      chk("t2_leap_day", day, 29);
      chk("t2_leap_flag", leap, 1);
      step(1'b0, 1'b1, pack(2023, 2, 28, 23, 59, 59));
      repeat (TPS) step(1'b1, 1'b0, '0);
      chk("t2_march", {month, day}, {4'd3, 5'd1});

      step(1'b0, 1'b1, pack(2100, 2, 29, 0, 0, 0));
      chk("t3_reject_hold", year, 2023);
      step(1'b0, 1'b1, pack(2000, 2, 29, 12, 0, 0));
      chk("t3_accept", year, 2000);

      step(1'b0, 1'b1, pack(4095, 12, 31, 23, 59, 59));
      repeat (TPS) step(1'b1, 1'b0, '0);
      chk("t4_year_wrap", year, 1);

      repeat (TPS - 1) step(1'b1, 1'b0, '0);
      step(1'b1, 1'b1, pack(2010, 6, 15, 10, 20, 30));
      chk("t5_loaded_held", second, 30);
      repeat (TPS - 1) step(1'b1, 1'b0, '0);
      chk("t5_presc_restart", second, 30);
      step(1'b1, 1'b0, '0);
      chk("t5_advance", second, 31);

`ifdef WATCH_ALARM_EN
      alarm_hms = {5'd7, 6'd0, 6'd0};
      al_sod = 7 * 3600;
      step(1'b0, 1'b1, pack(2020, 1, 1, 6, 59, 59));
      repeat (TPS) step(1'b1, 1'b0, '0);
      step(1'b0, 1'b1, pack(2020, 1, 1, 7, 0, 0));
      repeat (TPS) step(1'b1, 1'b0, '0);
`endif

      for (int i = 0; i < 3000; i++) begin
`ifdef WATCH_ALARM_EN
         if (i % 500 == 0) begin
            alarm_hms = {5'(23), 6'(59), 6'($urandom_range(50, 59))};
            al_sod = 23 * 3600 + 59 * 60 + int'(alarm_hms[5:0]);
         end
`endif
         if ($urandom_range(0, 39) == 0) begin
            pick = $urandom_range(0, 3);
            if (pick == 0) begin
               step($urandom_range(0, 1) == 1, 1'b1,
                    pack($urandom_range(0, 4095), $urandom_range(0, 15), $urandom_range(0, 31),
                         $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63)));
            end else begin
               y  = ($urandom_range(0, 1) == 1) ? ylist[$urandom_range(0, 6)] : $urandom_range(1, 4095);
               mo = $urandom_range(1, 12);
               d  = $urandom_range(27, 31);
               step($urandom_range(0, 1) == 1, 1'b1,
                    pack(y, mo, d, 23, 59, $urandom_range(50, 59)));
            end
         end else begin
            step($urandom_range(0, 2) != 0, 1'b0, '0);
         end
      end

      repeat (3) step(1'b0, 1'b0, '0);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
